// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Optional perf counters in pipe_hazard_ctrl are enabled by PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

  localparam int unsigned STATE_W         = 2;
  localparam int unsigned FCNT_W          = 2;
  localparam int unsigned FLUSH_DEPTH_MIN = 1;
  localparam int unsigned FLUSH_DEPTH_MAX = 3;

  typedef enum logic [STATE_W-1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use detector: an ID source matches the destination of a load in EX.
module pipe_hazard_detect #(
  parameter int unsigned REG_AW = 3
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_valid,
  input  logic              id_rt_valid,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);

  assign load_use = ex_load & ((id_rs_valid & (id_rs == ex_rd)) |
                               (id_rt_valid & (id_rt == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stalls, squashes, memory freezes and HLT draining.
// Define PIPE_CTRL_PERF_EN to add the stall_cnt / flush_cnt performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned FLUSH_DEPTH = 2
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int unsigned PERF_W      = 16
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic               id_rs_valid,
  input  logic               id_rt_valid,
  input  logic               ex_load,
  input  logic [REG_AW-1:0]  ex_rd,
  input  logic               ex_branch_taken,
  input  logic               mem_req,
  input  logic               mem_ack,
  input  logic               halt_in,
  input  logic               resume,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               idex_we,
  output logic               exmem_we,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic               halted,
  output logic [STATE_W-1:0] state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]  stall_cnt,
  output logic [PERF_W-1:0]  flush_cnt
`endif
);

  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_DEPTH - 1);
  localparam bit                MULTI_FLUSH = (FLUSH_DEPTH > FLUSH_DEPTH_MIN);

  pipe_state_e       state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              freeze, load_use;
  logic pc_we_c, ifid_we_c, idex_we_c, exmem_we_c, ifid_flush_c, idex_bubble_c, halted_c;

  assign freeze = mem_req & ~mem_ack;

  pipe_hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_valid (id_rs_valid),
    .id_rt_valid (id_rt_valid),
    .ex_load     (ex_load),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  // State register and flush down-counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state and Mealy controls; a taken branch from HALT behaves like one from RUN
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    pc_we_c       = 1'b1;
    ifid_we_c     = 1'b1;
    idex_we_c     = 1'b1;
    exmem_we_c    = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    halted_c      = 1'b0;
    if (freeze) begin
      pc_we_c    = 1'b0;
      ifid_we_c  = 1'b0;
      idex_we_c  = 1'b0;
      exmem_we_c = 1'b0;
      halted_c   = (state_q == HALT);
    end else begin
      case (state_q)
        RUN, HALT: begin
          if (ex_branch_taken) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            if (MULTI_FLUSH) begin
              state_d = FLUSH;
              fcnt_d  = FCNT_RELOAD;
            end else begin
              state_d = RUN;
            end
          end else if (state_q == HALT) begin
            pc_we_c       = 1'b0;
            ifid_we_c     = 1'b0;
            idex_bubble_c = 1'b1;
            halted_c      = 1'b1;
            if (resume) state_d = RUN;
          end else if (load_use) begin
            pc_we_c       = 1'b0;
            ifid_we_c     = 1'b0;
            idex_bubble_c = 1'b1;
          end else if (halt_in) begin
            pc_we_c       = 1'b0;
            ifid_we_c     = 1'b0;
            idex_bubble_c = 1'b1;
            state_d       = HALT;
          end
        end
        FLUSH: begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          if (ex_branch_taken) begin
            fcnt_d = FCNT_RELOAD;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
            if (fcnt_q == FCNT_W'(1)) state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  // Everything reads 0 while reset is held
  assign pc_we       = reset & pc_we_c;
  assign ifid_we     = reset & ifid_we_c;
  assign idex_we     = reset & idex_we_c;
  assign exmem_we    = reset & exmem_we_c;
  assign ifid_flush  = reset & ifid_flush_c;
  assign idex_bubble = reset & idex_bubble_c;
  assign halted      = reset & halted_c;
  assign state       = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc, flush_inc;

  assign stall_inc = freeze | ((state_q == RUN) & ~ex_branch_taken & load_use);
  assign flush_inc = ~freeze & ((state_q == FLUSH) | ex_branch_taken);

  // Saturating performance counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. Generates write-enable, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Resolves load-use hazards, taken-branch squashes, multi-cycle memory waits and HLT draining. Sits beside the decoder; its `idex_bubble` forces every ID/EX control bit (sw1–sw7, writeOrder) to 0 on the next edge.

## Interface
- `REG_AW`, 3 — register-number width
- `FLUSH_DEPTH`, 2 — cycles `ifid_flush` is asserted per taken branch, legal range 1–3
- `PERF_W`, 16 — perf counter width (only with `PIPE_CTRL_PERF_EN`)

Ports:
- `clock`  in  1  clock
- `reset`  in  1  asynchronous, active-low
- `id_rs`, `id_rt`  in  REG_AW  source registers of the instruction in ID
- `id_rs_valid`, `id_rt_valid`  in  1  the corresponding source is actually read
- `ex_load`  in  1  the instruction in EX is a load
- `ex_rd`  in  REG_AW  destination of the instruction in EX
- `ex_branch_taken`  in  1  branch in EX resolved taken
- `mem_req`  in  1  MEM stage has a multi-cycle access outstanding
- `mem_ack`  in  1  access completes this cycle
- `halt_in`  in  1  HLT decoded in ID
- `resume`  in  1  leave HALT
- `pc_we`, `ifid_we`, `idex_we`, `exmem_we`  out  1  register enables
- `ifid_flush`  out  1  load NOP into IF/ID
- `idex_bubble`  out  1  load all-zero controls into ID/EX
- `halted`  out  1  in HALT state
- `state`  out  2  current state encoding
- `stall_cnt`, `flush_cnt`  out  PERF_W  perf counters (macro only)

## Operation
- **States:** RUN=0, FLUSH=1, HALT=2. The FLUSH down-counter `fcnt` is 2 bits wide.
- **Output model:** outputs are Mealy, combinational from state and inputs. Default outputs are all enables 1, with `ifid_flush`, `idex_bubble` and `halted` at 0.
- **Freeze:** `freeze = mem_req & ~mem_ack` overrides every state.
  - All four enables are 0; `ifid_flush` and `idex_bubble` are 0.
  - State, `fcnt` and `halted` hold.
  - `stall_cnt` increments.
- **Priority in RUN (no freeze):**
  1. `ex_branch_taken`: `ifid_flush`=1 and `idex_bubble`=1. If `FLUSH_DEPTH`>1, go to FLUSH with `fcnt`=`FLUSH_DEPTH`-1. `flush_cnt` increments.
  2. Load-use, defined as `ex_load & ((id_rs_valid & id_rs==ex_rd) | (id_rt_valid & id_rt==ex_rd))`: `pc_we`=0, `ifid_we`=0, `idex_bubble`=1. Stay in RUN. `stall_cnt` increments.
  3. `halt_in`: `pc_we`=0, `ifid_we`=0, `idex_bubble`=1. Go to HALT.
- **FLUSH:**
  - Outputs: `ifid_flush`=1, `idex_bubble`=1; `pc_we` stays 1.
  - `fcnt` decrements each cycle; go to RUN when `fcnt`==1.
  - A new `ex_branch_taken` in FLUSH reloads `fcnt`=`FLUSH_DEPTH`-1.
  - Load-use and `halt_in` are ignored in FLUSH because the ID instruction is being squashed.
  - `flush_cnt` increments each cycle.
- **HALT:**
  - Outputs: `pc_we`=0, `ifid_we`=0, `idex_bubble`=1, `halted`=1. Older instructions drain through EX/MEM.
  - `ex_branch_taken` (an older branch, so the HLT was on the wrong path) takes the FLUSH entry actions and leaves HALT.
  - Otherwise `resume`=1 goes to RUN. The `resume` cycle still shows HALT outputs.
- **Counters:** saturate at all-ones; no wrap.

## Timing
- **Reset low (asynchronous):** state=RUN, `fcnt`=0, counters=0. All outputs are forced to 0 while reset is low, including all enables.
- **First edge after release:** normal RUN behaviour.
- **Latency:**
  - A hazard is acted on in the same cycle it appears; the registers see the control at the next rising edge.
  - A load-use stall is exactly 1 cycle, because the load advances to MEM.
  - A taken branch squashes for exactly `FLUSH_DEPTH` cycles, not counting freeze cycles.
- **`mem_req` with `mem_ack` high in the same cycle:** no freeze.
- **Freeze during FLUSH:** `fcnt` is preserved. The flush resumes after the ack and the total flush count is unchanged.
- **Branch and load-use in the same cycle:** the branch wins and no stall cycle is added.
- **Reset mid-FLUSH or mid-HALT:** returns to RUN with no residual flush.

## Configuration
- **`PIPE_CTRL_PERF_EN` defined:** the `stall_cnt` and `flush_cnt` ports and registers exist. `stall_cnt` counts load-use and freeze cycles; `flush_cnt` counts flush cycles.
- **Undefined:** the ports are absent, with no counter logic. All other behaviour is identical.

## Structure
- **Shared package `pipe_ctrl_pkg`:** state enum (RUN, FLUSH, HALT), state width constant, `FLUSH_DEPTH` legal min/max constants.
- **Sub-module `pipe_hazard_detect`:** purely combinational; produces `load_use` from the ID/EX register fields.
- **FSM and counters:** stay in the top module.

## Test plan
- Load r3 in EX with `id_rs`=3 valid -> one cycle of `pc_we`=0, `ifid_we`=0, `idex_bubble`=1; the same `id_rs`=3 with `id_rs_valid`=0 -> no stall.
- `ex_branch_taken` pulse with `FLUSH_DEPTH`=2 -> `ifid_flush`=1 for 2 cycles, `flush_cnt`=2, state RUN→FLUSH→RUN.
- `mem_req`=1 held 3 cycles with `mem_ack` on the 3rd -> all enables 0 for 2 cycles; `stall_cnt`=2.
- Branch then freeze on the next cycle -> the flush extends around the freeze; total `ifid_flush` cycles still = 2.
- `halt_in` -> `halted`=1; `ex_branch_taken` during HALT -> FLUSH and `halted`=0; in a separate run, `resume` -> RUN.
- Assert reset in FLUSH with `fcnt`=1 -> all outputs 0 immediately; after release, state=RUN and counters=0.
